// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Shift-add multiply and restoring divide on magnitudes, sign-corrected in a final FIX cycle.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               sgn_p_q, sgn_p_d;
  logic               sgn_r_q, sgn_r_d;
  logic               dbz_q, dbz_d;
  logic               done_q, done_d;
  logic               divz_q, divz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               is_signed;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] mul_acc, div_acc;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   quot, rem;

  assign is_signed = ~op[0];
  assign a_mag     = (is_signed && a[WIDTH-1]) ? -a : a;
  assign b_mag     = (is_signed && b[WIDTH-1]) ? -b : b;

  // opa_q is shifted left each iteration: it streams multiplier bits (MSB first)
  // for multiply and dividend bits into the partial remainder for divide.
  assign mul_acc = {acc_q[2*WIDTH-2:0], 1'b0} + (opa_q[WIDTH-1] ? {{WIDTH{1'b0}}, opb_q} : '0);
  assign trial   = {acc_q[2*WIDTH-1:WIDTH], opa_q[WIDTH-1]} - {1'b0, opb_q};
  assign div_acc = trial[WIDTH]
                 ? {acc_q[2*WIDTH-2:WIDTH], opa_q[WIDTH-1], acc_q[WIDTH-2:0], 1'b0}
                 : {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  assign quot = acc_q[WIDTH-1:0];
  assign rem  = acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    sgn_p_d  = sgn_p_q;
    sgn_r_d  = sgn_r_q;
    dbz_d    = dbz_q;
    done_d   = 1'b0;
    divz_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;

    case (state_q)
      S_IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start) begin
          is_div_d = op[1];
          opa_d    = a_mag;
          opb_d    = b_mag;
          sgn_p_d  = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          sgn_r_d  = is_signed & a[WIDTH-1];
          acc_d    = '0;
          cnt_d    = '0;
          dbz_d    = op[1] && (b == '0);
          state_d  = (op[1] && (b == '0)) ? S_FIX : S_CALC;
        end
      end
      S_CALC: begin
        acc_d = is_div_q ? div_acc : mul_acc;
        opa_d = opa_q << 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        divz_d  = dbz_q;
        if (!dbz_q) begin
          if (is_div_q) begin
            lo_d = sgn_p_q ? -quot : quot;
            hi_d = sgn_r_q ? -rem : rem;
          end else begin
            {hi_d, lo_d} = sgn_p_q ? -acc_q : acc_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      sgn_p_q  <= 1'b0;
      sgn_r_q  <= 1'b0;
      dbz_q    <= 1'b0;
      done_q   <= 1'b0;
      divz_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      sgn_p_q  <= sgn_p_d;
      sgn_r_q  <= sgn_r_d;
      dbz_q    <= dbz_d;
      done_q   <= done_d;
      divz_q   <= divz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign div_by_zero = divz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule
